pi1_copy: RTL and testbench

Bus-initiator block on the pi1 peripheral interface: copies a run of words from one pi1 word address range to another by issuing read (PIRDOP) then write (PIWROP) transactions, one word at a time. It drives requests into pi1 responders such as the GPIO and memory peripherals, and so sits on the initiator side of a pi1 port, typically behind the interconnect. Control comes from a simple start/length command interface driven by the CPU-side glue.

---
 rtl/pi1_pkg.sv | 19 +
 rtl/pi1_copy.sv | 144 ++++++++++++++
 tb/tb_pi1_copy.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pi1_pkg.sv
// Shared pi1 bus definitions: transaction op codes and the clog2 helper used
// by initiators and responders to derive word-address widths.
package pi1_pkg;

    localparam logic [1:0] PINOOP = 2'b00;
    localparam logic [1:0] PIWROP = 2'b01;
    localparam logic [1:0] PIRDOP = 2'b10;
    localparam logic [1:0] PIRWOP = 2'b11;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pi1_copy.sv
// pi1 initiator that copies len words from src to dst, one read then one write
// per word, in ascending address order. All bus outputs are registered.
module pi1_copy
    import pi1_pkg::*;
#(
    parameter  int ARCHBITSZ = 32,
    localparam int ADDRBITSZ = ARCHBITSZ - clog2(ARCHBITSZ / 8)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [ADDRBITSZ-1:0]     src_i,
    input  logic [ADDRBITSZ-1:0]     dst_i,
    input  logic [ADDRBITSZ-1:0]     len_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [1:0]               pi1_op_o,
    output logic [ADDRBITSZ-1:0]     pi1_addr_o,
    output logic [ARCHBITSZ-1:0]     pi1_data_o,
    input  logic [ARCHBITSZ-1:0]     pi1_data_i,
    output logic [ARCHBITSZ/8-1:0]   pi1_sel_o,
    input  logic                     pi1_rdy_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RDREQ,
        S_RDWAIT,
        S_WRREQ,
        S_DONE
    } state_e;

    localparam logic [ADDRBITSZ-1:0] ADDR_ONE = ADDRBITSZ'(1);

    state_e                 state_q, state_d;
    logic [ADDRBITSZ-1:0]   src_q, src_d;
    logic [ADDRBITSZ-1:0]   dst_q, dst_d;
    logic [ADDRBITSZ-1:0]   cnt_q, cnt_d;
    logic [ARCHBITSZ-1:0]   hold_q, hold_d;
    logic [1:0]             op_q, op_d;
    logic [ADDRBITSZ-1:0]   addr_q, addr_d;
    logic [ARCHBITSZ-1:0]   wdata_q, wdata_d;
    logic [ARCHBITSZ/8-1:0] sel_q, sel_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    src_d   = src_i;
                    dst_d   = dst_i;
                    cnt_d   = len_i;
                    state_d = (len_i == '0) ? S_DONE : S_RDREQ;
                end
            end
            S_RDREQ: begin
                if (pi1_rdy_i) state_d = S_RDWAIT;
            end
            S_RDWAIT: begin
                if (pi1_rdy_i) begin
                    hold_d  = pi1_data_i;
                    state_d = S_WRREQ;
                end
            end
            S_WRREQ: begin
                if (pi1_rdy_i) begin
                    src_d   = src_q + ADDR_ONE;
                    dst_d   = dst_q + ADDR_ONE;
                    cnt_d   = cnt_q - ADDR_ONE;
                    state_d = (cnt_q == ADDR_ONE) ? S_DONE : S_RDREQ;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Bus outputs are derived from the next state so they leave the flops
    // already aligned with the state they belong to; during a stall the
    // next state equals the current one, so the bus holds its value.
    always_comb begin
        op_d    = PINOOP;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_d)
            S_RDREQ: begin
                op_d   = PIRDOP;
                addr_d = src_d;
            end
            S_WRREQ: begin
                op_d    = PIWROP;
                addr_d  = dst_d;
                wdata_d = hold_d;
            end
            default: ;
        endcase
        sel_d  = (op_d != PINOOP) ? '1 : '0;
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            hold_q  <= '0;
            op_q    <= PINOOP;
            addr_q  <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign pi1_op_o   = op_q;
    assign pi1_addr_o = addr_q;
    assign pi1_data_o = wdata_q;
    assign pi1_sel_o  = sel_q;

endmodule

// File: tb/tb_pi1_copy.sv
// Bench for pi1_copy: a randomly stalling pi1 memory responder plus a plain
// word-by-word copy model of what memory should contain afterwards.
module tb_pi1_copy;
    import pi1_pkg::*;

    localparam int DW = 32;
    localparam int AW = 30;
    typedef logic [AW-1:0] addr_t;
    typedef logic [DW-1:0] word_t;
    typedef struct packed {
        logic [1:0] op;
        addr_t      addr;
        word_t      data;
    } xact_t;

    logic clk = 1'b0;
    logic rst_i = 1'b1;
    logic start_i = 1'b0;
    addr_t src_i = '0, dst_i = '0, len_i = '0;
    logic busy_o, done_o;
    logic [1:0] pi1_op_o;
    addr_t pi1_addr_o;
    word_t pi1_data_o;
    word_t pi1_data_i = '0;
    logic [3:0] pi1_sel_o;
    logic pi1_rdy_i = 1'b1;

    pi1_copy #(.ARCHBITSZ(DW)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
        .src_i(src_i), .dst_i(dst_i), .len_i(len_i),
        .busy_o(busy_o), .done_o(done_o),
        .pi1_op_o(pi1_op_o), .pi1_addr_o(pi1_addr_o), .pi1_data_o(pi1_data_o),
        .pi1_data_i(pi1_data_i), .pi1_sel_o(pi1_sel_o), .pi1_rdy_i(pi1_rdy_i)
    );

    initial forever #5 clk = ~clk;

    int checks = 0, errors = 0;
    int cyc = 0, start_cyc = 0, busy_cnt = 0;
    int stall_viol = 0, bad_sel = 0, bad_op = 0;
    int rdy_pct = 100;
    bit stall_on_wr = 1'b0;
    xact_t log_q[$];
    int done_q[$];
    word_t mem [addr_t];
    word_t ref_mem [addr_t];

    function automatic word_t dflt(addr_t a);
        return {2'b11, a} ^ 32'h3C3C_A5A5;
    endfunction
    function automatic word_t mem_rd(addr_t a);
        return mem.exists(a) ? mem[a] : dflt(a);
    endfunction
    function automatic word_t ref_rd(addr_t a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Responder and protocol monitor: everything seen at a falling edge is
    // what the following rising edge will sample.
    initial begin
        bit rd_pend, stall_prev, rdy;
        addr_t rd_addr, p_addr;
        logic [1:0] p_op;
        word_t p_data;
        logic [3:0] p_sel;
        rd_pend = 0; stall_prev = 0; rd_addr = '0;
        p_op = '0; p_addr = '0; p_data = '0; p_sel = '0;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                rd_pend = 0;
            end else begin
                if (stall_prev && (pi1_op_o !== p_op || pi1_addr_o !== p_addr ||
                                   pi1_data_o !== p_data || pi1_sel_o !== p_sel))
                    stall_viol++;
                if (pi1_op_o === PIRWOP) bad_op++;
                if (pi1_sel_o !== ((pi1_op_o != PINOOP) ? 4'hF : 4'h0)) bad_sel++;
                if (done_o) done_q.push_back(cyc - start_cyc);
                if (busy_o) busy_cnt++;
            end
            rdy = ($urandom_range(99) < 32'(rdy_pct));
            if (stall_on_wr && pi1_op_o == PIWROP) rdy = 0;
            pi1_rdy_i  = rdy;
            pi1_data_i = (rd_pend && rdy) ? mem_rd(rd_addr) : word_t'($urandom);
            if (!rst_i && rdy) begin
                rd_pend = 0;
                if (pi1_op_o != PINOOP) begin
                    log_q.push_back('{op: pi1_op_o, addr: pi1_addr_o, data: pi1_data_o});
                    if (pi1_op_o == PIWROP) mem[pi1_addr_o] = pi1_data_o;
                    if (pi1_op_o == PIRDOP) begin
                        rd_pend = 1;
                        rd_addr = pi1_addr_o;
                    end
                end
            end
            stall_prev = !rst_i && (pi1_op_o != PINOOP) && !rdy;
            p_op = pi1_op_o; p_addr = pi1_addr_o; p_data = pi1_data_o; p_sel = pi1_sel_o;
        end
    end

    task automatic do_start(input addr_t s, input addr_t d, input addr_t n);
        @(negedge clk); #1;
        log_q.delete();
        done_q.delete();
        busy_cnt  = 0;
        start_cyc = cyc;
        start_i = 1'b1; src_i = s; dst_i = d; len_i = n;
        @(negedge clk); #1;
        start_i = 1'b0;
        src_i = addr_t'($urandom); dst_i = addr_t'($urandom); len_i = addr_t'($urandom);
    endtask

    task automatic wait_done(input string name, input int bound);
        int n = 0;
        while (done_q.size() == 0 && n < bound) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if (done_q.size() == 0) begin
            errors++;
            $display("FAIL %s: done_o timeout after %0d cycles, expected a pulse", name, bound);
        end
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic fill_src(input addr_t s, input int n);
        for (int i = 0; i < n; i++) mem[s + addr_t'(i)] = word_t'($urandom);
        ref_mem = mem;
    endtask

    // Expected memory: words copied one at a time, lowest address first.
    task automatic check_copy(input string name, input addr_t s, input addr_t d, input int n);
        int rd_cnt, wr_cnt;
        for (int i = 0; i < n; i++) ref_mem[d + addr_t'(i)] = ref_rd(s + addr_t'(i));
        for (int i = 0; i < n; i++) begin
            addr_t a = d + addr_t'(i);
            checks++;
            if (mem_rd(a) !== ref_rd(a)) begin
                errors++;
                $display("FAIL %s mem[%0h]: got %0h exp %0h", name, a, mem_rd(a), ref_rd(a));
            end
        end
        for (int i = 0; i < n; i++) begin
            rd_cnt = 0; wr_cnt = 0;
            foreach (log_q[k]) begin
                if (log_q[k].op == PIRDOP && log_q[k].addr == s + addr_t'(i)) rd_cnt++;
                if (log_q[k].op == PIWROP && log_q[k].addr == d + addr_t'(i)) wr_cnt++;
            end
            checks++;
            if (rd_cnt != 1 || wr_cnt != 1) begin
                errors++;
                $display("FAIL %s word %0d access count: rd %0d wr %0d exp 1 1", name, i, rd_cnt, wr_cnt);
            end
        end
        checks++;
        if (log_q.size() != 2 * n) begin
            errors++;
            $display("FAIL %s op count: got %0d exp %0d", name, log_q.size(), 2 * n);
        end
    endtask

    task automatic check_bus_seq(input string name, input xact_t exp_q[$]);
        checks++;
        if (log_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s seq length: got %0d exp %0d", name, log_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[k]) begin
                checks++;
                if (log_q[k].op !== exp_q[k].op || log_q[k].addr !== exp_q[k].addr ||
                    (exp_q[k].op == PIWROP && log_q[k].data !== exp_q[k].data)) begin
                    errors++;
                    $display("FAIL %s op %0d: got op%0d @%0h d%0h exp op%0d @%0h d%0h", name, k,
                             log_q[k].op, log_q[k].addr, log_q[k].data,
                             exp_q[k].op, exp_q[k].addr, exp_q[k].data);
                end
            end
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d exp %0d", name, got, exp);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_int("reset op", int'(pi1_op_o), 0);
        check_int("reset sel", int'(pi1_sel_o), 0);
        check_int("reset addr", int'(pi1_addr_o), 0);
        check_int("reset data", int'(pi1_data_o), 0);
        check_int("reset busy", int'(busy_o), 0);
        check_int("reset done", int'(done_o), 0);
        rst_i = 1'b0;
    endtask

    task automatic test_basic();
        xact_t exp_q[$];
        word_t w[3];
        rdy_pct = 100;
        mem.delete();
        for (int i = 0; i < 3; i++) begin
            w[i] = word_t'($urandom);
            mem[addr_t'(32'h10 + i)] = w[i];
        end
        ref_mem = mem;
        do_start(addr_t'(32'h10), addr_t'(32'h40), addr_t'(3));
        wait_done("basic", 50);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back('{op: PIRDOP, addr: addr_t'(32'h10 + i), data: '0});
            exp_q.push_back('{op: PIWROP, addr: addr_t'(32'h40 + i), data: w[i]});
        end
        check_bus_seq("basic", exp_q);
        if (done_q.size() > 0) check_int("basic done cycle", done_q[0], 10);
        check_int("basic busy cycles", busy_cnt, 10);
        check_copy("basic", addr_t'(32'h10), addr_t'(32'h40), 3);
    endtask

    task automatic test_len0();
        rdy_pct = 100;
        do_start(addr_t'(32'h20), addr_t'(32'h80), '0);
        wait_done("len0", 20);
        check_int("len0 ops", log_q.size(), 0);
        if (done_q.size() > 0) check_int("len0 done cycle", done_q[0], 1);
        check_int("len0 busy cycles", busy_cnt, 1);
        check_int("len0 done pulses", done_q.size(), 1);
    endtask

    task automatic test_random_stall();
        for (int it = 0; it < 4; it++) begin
            addr_t s, d;
            s = addr_t'($urandom);
            d = (it == 0) ? s + addr_t'(32'h100) : s + addr_t'($urandom_range(10)) - addr_t'(5);
            rdy_pct = 50;
            mem.delete();
            fill_src(s, 4);
            stall_viol = 0;
            do_start(s, d, addr_t'(4));
            wait_done("stall", 500);
            check_copy("stall", s, d, 4);
            check_int("stall stability", stall_viol, 0);
        end
        rdy_pct = 100;
    endtask

    task automatic test_wrap();
        xact_t exp_q[$];
        addr_t d;
        rdy_pct = 100;
        mem.delete();
        d = addr_t'($urandom_range(32'h1000, 32'h2000));
        mem['1] = word_t'($urandom);
        mem['0] = word_t'($urandom);
        ref_mem = mem;
        do_start('1, d, addr_t'(2));
        wait_done("wrap", 50);
        exp_q.push_back('{op: PIRDOP, addr: '1, data: '0});
        exp_q.push_back('{op: PIWROP, addr: d, data: ref_rd('1)});
        exp_q.push_back('{op: PIRDOP, addr: '0, data: '0});
        exp_q.push_back('{op: PIWROP, addr: d + addr_t'(1), data: ref_rd('0)});
        check_bus_seq("wrap", exp_q);
    endtask

    task automatic test_ignore_start();
        int n = 0;
        rdy_pct = 100;
        mem.delete();
        fill_src(addr_t'(32'h300), 2);
        do_start(addr_t'(32'h300), addr_t'(32'h380), addr_t'(2));
        start_i = 1'b1; src_i = addr_t'(32'h500); dst_i = addr_t'(32'h600); len_i = addr_t'(5);
        @(negedge clk); #1;
        start_i = 1'b0;
        while (done_q.size() == 0 && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        start_i = 1'b1; src_i = addr_t'(32'h700); dst_i = addr_t'(32'h780); len_i = addr_t'(3);
        @(negedge clk); #1;
        start_i = 1'b0;
        repeat (12) @(negedge clk);
        #1;
        check_int("ignore done pulses", done_q.size(), 1);
        if (done_q.size() > 0) check_int("ignore done cycle", done_q[0], 7);
        check_int("ignore ops", log_q.size(), 4);
        check_int("ignore busy after", int'(busy_o), 0);
        check_copy("ignore", addr_t'(32'h300), addr_t'(32'h380), 2);
    endtask

    task automatic test_reset_mid();
        int n = 0;
        rdy_pct = 100;
        stall_on_wr = 1'b1;
        mem.delete();
        fill_src(addr_t'(32'h900), 3);
        do_start(addr_t'(32'h900), addr_t'(32'hA00), addr_t'(3));
        while (pi1_op_o != PIWROP && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        check_int("rstmid reached write", int'(pi1_op_o), int'(PIWROP));
        rst_i = 1'b1;
        @(negedge clk); #1;
        check_int("rstmid op", int'(pi1_op_o), int'(PINOOP));
        check_int("rstmid busy", int'(busy_o), 0);
        check_int("rstmid done", int'(done_o), 0);
        rst_i = 1'b0;
        stall_on_wr = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        check_int("rstmid no done", done_q.size(), 0);
        check_int("rstmid no write", mem.exists(addr_t'(32'hA00)) ? 1 : 0, 0);
        ref_mem = mem;
        do_start(addr_t'(32'h901), addr_t'(32'hB00), addr_t'(1));
        wait_done("rstmid follow", 50);
        if (done_q.size() > 0) check_int("rstmid follow done cycle", done_q[0], 4);
        check_copy("rstmid follow", addr_t'(32'h901), addr_t'(32'hB00), 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_len0();
        test_random_stall();
        test_wrap();
        test_ignore_start();
        test_reset_mid();
        check_int("sel rule violations", bad_sel, 0);
        check_int("PIRWOP issued", bad_op, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
